voice_sequencer: RTL and testbench

VOICE_SEQUENCER -- requirements
Module: voice_sequencer

---
 rtl/voice_sequencer_if.sv | 24 ++
 rtl/voice_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_voice_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_sequencer_if.sv
// rtl/voice_sequencer_if.sv - request, status and player handshake bundle for voice_sequencer
interface voice_sequencer_if;
  logic       start;
  logic [7:0] value;
  logic       kind;
  logic       player_busy;
  logic [4:0] clip_code;
  logic       clip_valid;
  logic       busy;
  logic       done;
  logic       timeout_err;

  // Requester/player side: drives the request and the player busy flag
  modport master (
    output start, value, kind, player_busy,
    input  clip_code, clip_valid, busy, done, timeout_err
  );

  // Sequencer side
  modport slave (
    input  start, value, kind, player_busy,
    output clip_code, clip_valid, busy, done, timeout_err
  );
endinterface

// File: rtl/voice_sequencer.sv
// rtl/voice_sequencer.sv - splits a reading into digits and plays the matching voice clips
module voice_sequencer #(
  parameter int unsigned ACK_TIMEOUT  = 1000,
  parameter int unsigned DONE_TIMEOUT = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  voice_sequencer_if.slave bus
);
  localparam int unsigned MAX_TO = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned TW     = ($clog2(MAX_TO + 1) > 21) ? $clog2(MAX_TO + 1) : 21;
  localparam logic [TW-1:0] ACK_LIMIT  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] DONE_LIMIT = TW'(DONE_TIMEOUT - 1);

  localparam logic [4:0] C_PRE_HR  = 5'b00001;
  localparam logic [4:0] C_PRE_SP  = 5'b00010;
  localparam logic [4:0] C_HUNDRED = 5'b00011;
  localparam logic [4:0] C_SUF_HR  = 5'b00100;
  localparam logic [4:0] C_SUF_SP  = 5'b00110;
  localparam logic [4:0] C_ZERO    = 5'b11110;

  typedef enum logic [2:0] {IDLE, CONV, SELECT, ISSUE, WAIT_ACK, WAIT_DONE, FINISH} state_t;

  // Unit clips count down from ZERO (11110); tens clips count down from ten (10100)
  function automatic logic [4:0] unit_code(input logic [3:0] d);
    return 5'd30 - 5'(d);
  endfunction

  function automatic logic [4:0] tens_code(input logic [3:0] d);
    return 5'd21 - 5'(d);
  endfunction

  state_t        state_q, state_d;
  logic          kind_q, kind_d;
  logic [7:0]    rem_q, rem_d;
  logic [1:0]    h_q, h_d;
  logic [3:0]    t_q, t_d;
  logic [3:0]    u_q, u_d;
  logic [2:0]    step_q, step_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    clip_code_q, clip_code_d;
  logic          clip_valid_q, clip_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          terr_q, terr_d;

  // Clip slots: prefix, hundreds digit, HUNDRED, tens/ZERO, units, suffix
  logic [5:0] clip_ok;
  logic [4:0] clip_tbl [0:5];
  logic       sel_found;
  logic [2:0] sel_idx;
  logic [4:0] sel_code;

  // Build the clip slot table and find the first present slot at or after step_q
  always_comb begin
    clip_ok     = '0;
    clip_ok[0]  = 1'b1;
    clip_ok[1]  = (h_q != 2'd0);
    clip_ok[2]  = (h_q != 2'd0);
    clip_ok[3]  = (t_q != 4'd0) || ((h_q != 2'd0) && (u_q != 4'd0));
    clip_ok[4]  = (u_q != 4'd0) || ((h_q == 2'd0) && (t_q == 4'd0));
    clip_ok[5]  = 1'b1;
    clip_tbl[0] = kind_q ? C_PRE_SP : C_PRE_HR;
    clip_tbl[1] = unit_code({2'b00, h_q});
    clip_tbl[2] = C_HUNDRED;
    clip_tbl[3] = (t_q != 4'd0) ? tens_code(t_q) : C_ZERO;
    clip_tbl[4] = unit_code(u_q);
    clip_tbl[5] = kind_q ? C_SUF_SP : C_SUF_HR;
    sel_found   = 1'b0;
    sel_idx     = 3'd0;
    sel_code    = 5'd0;
    for (int i = 5; i >= 0; i--) begin
      if (clip_ok[i] && (3'(i) >= step_q)) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_code  = clip_tbl[i];
      end
    end
  end

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    rem_d        = rem_q;
    h_d          = h_q;
    t_d          = t_q;
    u_d          = u_q;
    step_d       = step_q;
    clip_code_d  = clip_code_q;
    clip_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    terr_d       = terr_q;
    tmr_d        = (&tmr_q) ? tmr_q : tmr_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          kind_d  = bus.kind;
          rem_d   = bus.value;
          h_d     = 2'd0;
          t_d     = 4'd0;
          u_d     = 4'd0;
          step_d  = 3'd0;
          busy_d  = 1'b1;
          terr_d  = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (rem_q >= 8'd100) begin
          rem_d = rem_q - 8'd100;
          h_d   = h_q + 2'd1;
        end else if (rem_q >= 8'd10) begin
          rem_d = rem_q - 8'd10;
          t_d   = t_q + 4'd1;
        end else begin
          u_d     = rem_q[3:0];
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (!sel_found) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FINISH;
        end else if (!bus.player_busy) begin
          clip_code_d  = sel_code;
          clip_valid_d = 1'b1;
          step_d       = sel_idx + 3'd1;
          state_d      = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.player_busy) begin
          state_d = WAIT_DONE;
        end else if (tmr_q >= ACK_LIMIT) begin
          terr_d  = 1'b1;
          state_d = SELECT;
        end
      end
      WAIT_DONE: begin
        if (!bus.player_busy) begin
          state_d = SELECT;
        end else if (tmr_q >= DONE_LIMIT) begin
          terr_d  = 1'b1;
          state_d = SELECT;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) tmr_d = '0;
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      kind_q       <= 1'b0;
      rem_q        <= 8'd0;
      h_q          <= 2'd0;
      t_q          <= 4'd0;
      u_q          <= 4'd0;
      step_q       <= 3'd0;
      tmr_q        <= '0;
      clip_code_q  <= 5'd0;
      clip_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      rem_q        <= rem_d;
      h_q          <= h_d;
      t_q          <= t_d;
      u_q          <= u_d;
      step_q       <= step_d;
      tmr_q        <= tmr_d;
      clip_code_q  <= clip_code_d;
      clip_valid_q <= clip_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
    end
  end

  assign bus.clip_code   = clip_code_q;
  assign bus.clip_valid  = clip_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_voice_sequencer.sv
// tb/tb_voice_sequencer.sv - randomized self-checking bench for voice_sequencer
module tb_voice_sequencer;
  localparam int ACK_TO  = 8;
  localparam int DONE_TO = 64;
  localparam int BUDGET  = 3000;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  voice_sequencer_if vif();

  voice_sequencer #(.ACK_TIMEOUT(ACK_TO), .DONE_TIMEOUT(DONE_TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (vif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [4:0] got_q[$];
  int         got_t[$];
  logic [4:0] exp_q[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         player_mode = 0;
  int         ack_dly = 3;
  int         play_len = 20;

  logic [4:0] unit_tab[10] = '{5'b11110, 5'b11101, 5'b11100, 5'b11011, 5'b11010,
                               5'b11001, 5'b11000, 5'b10111, 5'b10110, 5'b10101};
  logic [4:0] tens_tab[10] = '{5'b00000, 5'b10100, 5'b10011, 5'b10010, 5'b10001,
                               5'b10000, 5'b01111, 5'b01110, 5'b01101, 5'b01100};

  // Record every strobed clip with its cycle number, and count done pulses
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (vif.clip_valid === 1'b1) begin
        got_q.push_back(vif.clip_code);
        got_t.push_back(cyc);
      end
      if (vif.done === 1'b1) done_cnt++;
    end
  end

  // Player chip model: mode 0 acks after ack_dly and plays play_len, mode 1 never responds
  initial begin
    vif.player_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (vif.clip_valid === 1'b1 && player_mode == 0) begin
        repeat (ack_dly) @(negedge clk);
        vif.player_busy = 1'b1;
        repeat (play_len) @(negedge clk);
        vif.player_busy = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Expected clip list from the announcement rules, using decimal arithmetic
  task automatic build_exp(input int v, input bit k);
    int h, t, u;
    h = v / 100;
    t = (v % 100) / 10;
    u = v % 10;
    exp_q.delete();
    exp_q.push_back(k ? 5'b00010 : 5'b00001);
    if (h > 0) begin
      exp_q.push_back(unit_tab[h]);
      exp_q.push_back(5'b00011);
    end
    if (t > 0) exp_q.push_back(tens_tab[t]);
    else if (h > 0 && u > 0) exp_q.push_back(5'b11110);
    if (u > 0 || v == 0) exp_q.push_back(unit_tab[u]);
    exp_q.push_back(k ? 5'b00110 : 5'b00100);
  endtask

  task automatic pulse_start(input int v, input bit k);
    @(negedge clk);
    vif.start = 1'b1;
    vif.value = 8'(v);
    vif.kind  = k;
    @(negedge clk);
    vif.start = 1'b0;
    vif.value = 8'($urandom);
    vif.kind  = 1'($urandom);
  endtask

  task automatic wait_done(input int d0, output bit fin);
    fin = 1'b0;
    for (int i = 0; i < BUDGET && !fin; i++) begin
      @(negedge clk);
      if (done_cnt != d0) fin = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    vif.start = 1'b0;
    vif.value = 8'd0;
    vif.kind  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (vif.clip_code !== 5'b0) begin errors++; $display("FAIL reset_clip_code: got %b expected 00000", vif.clip_code); end
    checks++; if (vif.clip_valid !== 1'b0) begin errors++; $display("FAIL reset_clip_valid: got %b expected 0", vif.clip_valid); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", vif.busy); end
    checks++; if (vif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", vif.done); end
    checks++; if (vif.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", vif.timeout_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_vectors();
    int vv[10] = '{75, 0, 105, 120, 255, 100, 110, 9, 10, 99};
    int vk[10] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 1};
    int n0, d0;
    bit fin;
    player_mode = 0; ack_dly = 3; play_len = 20;
    for (int j = 0; j < 10; j++) begin
      build_exp(vv[j], vk[j][0]);
      n0 = got_q.size(); d0 = done_cnt;
      pulse_start(vv[j], vk[j][0]);
      checks++; if (vif.busy !== 1'b1) begin errors++; $display("FAIL vec_busy_rise v=%0d: got %b expected 1", vv[j], vif.busy); end
      wait_done(d0, fin);
      checks++; if (!fin) begin errors++; $display("FAIL vec_done_timeout v=%0d: got no done expected done", vv[j]); end
      checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL vec_clip_count v=%0d: got %0d expected %0d", vv[j], got_q.size() - n0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
        checks++; if (got_q[n0 + i] !== exp_q[i]) begin errors++; $display("FAIL vec_clip v=%0d idx=%0d: got %b expected %b", vv[j], i, got_q[n0 + i], exp_q[i]); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL vec_done_count v=%0d: got %0d expected 1", vv[j], done_cnt - d0); end
      checks++; if (vif.timeout_err !== 1'b0) begin errors++; $display("FAIL vec_timeout_err v=%0d: got %b expected 0", vv[j], vif.timeout_err); end
      checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL vec_busy_fall v=%0d: got %b expected 0", vv[j], vif.busy); end
    end
  endtask

  task automatic test_random();
    int n0, d0, v;
    bit k, fin;
    player_mode = 0;
    for (int j = 0; j < 20; j++) begin
      v = $urandom_range(0, 255);
      k = 1'($urandom);
      ack_dly = $urandom_range(1, 5);
      play_len = $urandom_range(1, 30);
      build_exp(v, k);
      n0 = got_q.size(); d0 = done_cnt;
      pulse_start(v, k);
      wait_done(d0, fin);
      checks++; if (!fin) begin errors++; $display("FAIL rnd_done_timeout v=%0d: got no done expected done", v); end
      checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL rnd_clip_count v=%0d: got %0d expected %0d", v, got_q.size() - n0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
        checks++; if (got_q[n0 + i] !== exp_q[i]) begin errors++; $display("FAIL rnd_clip v=%0d idx=%0d: got %b expected %b", v, i, got_q[n0 + i], exp_q[i]); end
      end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rnd_done_count v=%0d: got %0d expected 1", v, done_cnt - d0); end
      checks++; if (vif.timeout_err !== 1'b0) begin errors++; $display("FAIL rnd_timeout_err v=%0d: got %b expected 0", v, vif.timeout_err); end
    end
  endtask

  task automatic test_ack_timeout();
    int n0, d0, v;
    bit fin;
    player_mode = 1;
    v = $urandom_range(101, 255);
    build_exp(v, 1'b0);
    n0 = got_q.size(); d0 = done_cnt;
    pulse_start(v, 1'b0);
    wait_done(d0, fin);
    checks++; if (!fin) begin errors++; $display("FAIL ack_to_done: got no done expected done"); end
    checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL ack_to_clip_count: got %0d expected %0d", got_q.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
      checks++; if (got_q[n0 + i] !== exp_q[i]) begin errors++; $display("FAIL ack_to_clip idx=%0d: got %b expected %b", i, got_q[n0 + i], exp_q[i]); end
    end
    for (int i = 1; i < exp_q.size() && n0 + i < got_t.size(); i++) begin
      checks++; if (got_t[n0 + i] - got_t[n0 + i - 1] != ACK_TO + 2) begin errors++; $display("FAIL ack_to_gap idx=%0d: got %0d expected %0d", i, got_t[n0 + i] - got_t[n0 + i - 1], ACK_TO + 2); end
    end
    checks++; if (vif.timeout_err !== 1'b1) begin errors++; $display("FAIL ack_to_flag: got %b expected 1", vif.timeout_err); end
    player_mode = 0; ack_dly = 2; play_len = 5;
    d0 = done_cnt;
    pulse_start(7, 1'b1);
    checks++; if (vif.timeout_err !== 1'b0) begin errors++; $display("FAIL ack_to_clear: got %b expected 0", vif.timeout_err); end
    wait_done(d0, fin);
    checks++; if (!fin) begin errors++; $display("FAIL ack_to_next_done: got no done expected done"); end
  endtask

  task automatic test_done_timeout();
    int n0, d0;
    bit fin;
    player_mode = 0; ack_dly = 2; play_len = DONE_TO + 6;
    build_exp(42, 1'b1);
    n0 = got_q.size(); d0 = done_cnt;
    pulse_start(42, 1'b1);
    wait_done(d0, fin);
    checks++; if (!fin) begin errors++; $display("FAIL done_to_done: got no done expected done"); end
    checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL done_to_clip_count: got %0d expected %0d", got_q.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
      checks++; if (got_q[n0 + i] !== exp_q[i]) begin errors++; $display("FAIL done_to_clip idx=%0d: got %b expected %b", i, got_q[n0 + i], exp_q[i]); end
    end
    checks++; if (vif.timeout_err !== 1'b1) begin errors++; $display("FAIL done_to_flag: got %b expected 1", vif.timeout_err); end
  endtask

  task automatic test_start_while_busy();
    int n0, d0, v;
    bit fin;
    player_mode = 0; ack_dly = 2; play_len = 10;
    v = $urandom_range(100, 255);
    build_exp(v, 1'b0);
    n0 = got_q.size(); d0 = done_cnt;
    pulse_start(v, 1'b0);
    for (int j = 0; j < 3; j++) begin
      repeat (7) @(negedge clk);
      vif.start = 1'b1;
      vif.value = 8'($urandom);
      vif.kind  = 1'b1;
      @(negedge clk);
      vif.start = 1'b0;
    end
    wait_done(d0, fin);
    checks++; if (!fin) begin errors++; $display("FAIL busy_start_done: got no done expected done"); end
    checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL busy_start_clip_count: got %0d expected %0d", got_q.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
      checks++; if (got_q[n0 + i] !== exp_q[i]) begin errors++; $display("FAIL busy_start_clip idx=%0d: got %b expected %b", i, got_q[n0 + i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int n0, d0, n1;
    bit seen, fin;
    player_mode = 0; ack_dly = 1; play_len = 4;
    d0 = done_cnt;
    pulse_start(33, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (vif.done === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_first_done: got no done expected done"); end
    vif.start = 1'b1;
    vif.value = 8'd222;
    vif.kind  = 1'b1;
    build_exp(150, 1'b0);
    n1 = got_q.size();
    @(negedge clk);
    vif.value = 8'd150;
    vif.kind  = 1'b0;
    @(negedge clk);
    vif.start = 1'b0;
    checks++; if (vif.busy !== 1'b1) begin errors++; $display("FAIL b2b_next_accept: got busy=%b expected 1", vif.busy); end
    n0 = n1; d0 = done_cnt;
    wait_done(d0, fin);
    checks++; if (!fin) begin errors++; $display("FAIL b2b_second_done: got no done expected done"); end
    checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL b2b_clip_count: got %0d expected %0d", got_q.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
      checks++; if (got_q[n0 + i] !== exp_q[i]) begin errors++; $display("FAIL b2b_clip idx=%0d: got %b expected %b", i, got_q[n0 + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n0, d0, v;
    bit fin, reached;
    player_mode = 0; ack_dly = 2; play_len = 20;
    v = $urandom_range(100, 255);
    n0 = got_q.size();
    pulse_start(v, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < BUDGET && !reached; i++) begin
      @(negedge clk);
      if (got_q.size() >= n0 + 2) reached = 1'b1;
    end
    repeat (8) @(negedge clk);
    checks++; if (vif.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_busy: got %b expected 1", vif.busy); end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (vif.clip_code !== 5'b0) begin errors++; $display("FAIL rst_mid_clip_code: got %b expected 00000", vif.clip_code); end
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", vif.busy); end
    checks++; if (vif.clip_valid !== 1'b0 || vif.done !== 1'b0 || vif.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %b%b%b expected 000", vif.clip_valid, vif.done, vif.timeout_err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected %0d", done_cnt, d0); end
    v = $urandom_range(0, 255);
    build_exp(v, 1'b1);
    n0 = got_q.size(); d0 = done_cnt;
    pulse_start(v, 1'b1);
    wait_done(d0, fin);
    checks++; if (!fin) begin errors++; $display("FAIL rst_mid_next_done: got no done expected done"); end
    checks++; if (got_q.size() - n0 != exp_q.size()) begin errors++; $display("FAIL rst_mid_clip_count: got %0d expected %0d", got_q.size() - n0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
      checks++; if (got_q[n0 + i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_clip idx=%0d: got %b expected %b", i, got_q[n0 + i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_ack_timeout();
    test_done_timeout();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
